pwm_fade_controller: RTL and testbench

Upstream parameter source for `PWMGenerator`: ramps the duty cycle one count at a time from its current value to a requested target at a programmable rate. It drives the generator's `pwm_period`, `pwm_duty_cycle` and `update_parameters` inputs directly. It guarantees the generator is never handed a duty cycle ≥ period. It is used for LED fades and motor soft-start, where step changes in duty are unacceptable.

---
 rtl/pwm_fade_controller.sv | 131 +++++++++++++
 tb/tb_pwm_fade_controller.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_controller.sv
// Duty-cycle fader feeding a PWM generator: ramps duty one count per step toward a
// clamped target, pulsing update_parameters on every change.
//
//   state  | meaning
//   IDLE   | no fade pending, outputs hold
//   LOAD   | new period/duty presented, interval counter loaded
//   WAIT   | counting down the step interval
//   STEP   | duty moved one count toward target
//   DONE   | target reached, done pulse
module pwm_fade_controller #(
  parameter int WIDTH      = 4,
  parameter int RATE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      period_in,
  input  logic [WIDTH-1:0]      target_duty,
  input  logic [RATE_WIDTH-1:0] step_interval,
  output logic [WIDTH-1:0]      pwm_period,
  output logic [WIDTH-1:0]      pwm_duty_cycle,
  output logic                  update_parameters,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_STEP, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      period_q, period_d;
  logic [WIDTH-1:0]      duty_q, duty_d;
  logic [WIDTH-1:0]      tgt_q, tgt_d;
  logic [RATE_WIDTH-1:0] ivl_q, ivl_d;
  logic [RATE_WIDTH-1:0] cnt_q, cnt_d;
  logic                  upd_q, upd_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [WIDTH-1:0]      ceil_in;
  logic [WIDTH-1:0]      tgt_in;
  logic                  advance;

  // A zero period yields a zero ceiling, which also forces the target to zero.
  assign ceil_in = (period_in == '0) ? '0 : period_in - WIDTH'(1);
  assign tgt_in  = (target_duty < period_in) ? target_duty : ceil_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      period_q <= '0;
      duty_q   <= '0;
      tgt_q    <= '0;
      ivl_q    <= '0;
      cnt_q    <= '0;
      upd_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      tgt_q    <= tgt_d;
      ivl_q    <= ivl_d;
      cnt_q    <= cnt_d;
      upd_q    <= upd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    duty_d   = duty_q;
    tgt_d    = tgt_q;
    ivl_d    = ivl_q;
    cnt_d    = cnt_q;
    upd_d    = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    advance  = 1'b0;

    if (start) begin
      state_d  = S_LOAD;
      period_d = period_in;
      tgt_d    = tgt_in;
      ivl_d    = step_interval;
      cnt_d    = step_interval;
      duty_d   = (duty_q > ceil_in) ? ceil_in : duty_q;
      upd_d    = 1'b1;
      busy_d   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_LOAD, S_STEP: begin
          if (duty_q == tgt_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end
        S_WAIT:  advance = 1'b1;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase

      // Outputs are registered, so the step is issued on the edge where the
      // counter already reads zero; the pulse spacing is therefore interval+1.
      if (advance) begin
        busy_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_STEP;
          duty_d  = (duty_q < tgt_q) ? duty_q + WIDTH'(1) : duty_q - WIDTH'(1);
          cnt_d   = ivl_q;
          upd_d   = 1'b1;
        end else begin
          state_d = S_WAIT;
          cnt_d   = cnt_q - RATE_WIDTH'(1);
        end
      end
    end
  end

  assign pwm_period        = period_q;
  assign pwm_duty_cycle    = duty_q;
  assign update_parameters = upd_q;
  assign busy              = busy_q;
  assign done              = done_q;

endmodule

// File: tb/tb_pwm_fade_controller.sv
// Bench for pwm_fade_controller: schedule-based reference model compared every cycle,
// plus directed fades with hand-computed update offsets, duties and done timing.
module tb_pwm_fade_controller;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] period_in;
  logic [3:0] target_duty;
  logic [7:0] step_interval;
  logic [3:0] pwm_period;
  logic [3:0] pwm_duty_cycle;
  logic       update_parameters;
  logic       busy;
  logic       done;

  pwm_fade_controller #(.WIDTH(4), .RATE_WIDTH(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .period_in         (period_in),
    .target_duty       (target_duty),
    .step_interval     (step_interval),
    .pwm_period        (pwm_period),
    .pwm_duty_cycle    (pwm_duty_cycle),
    .update_parameters (update_parameters),
    .busy              (busy),
    .done              (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a fade is a schedule of pulse times, not a state machine.
  int cyc = 0, m_start_cyc = 0, next_pulse = 0, done_at = -1;
  int m_period = 0, m_duty = 0, m_tgt = 0, m_ivl = 0, ceil_v = 0;
  bit active = 0, e_upd = 0, e_done = 0, e_busy = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_period = 0; m_duty = 0; m_tgt = 0; m_ivl = 0;
      active = 0; done_at = -1; e_upd = 0; e_done = 0; e_busy = 0;
    end else begin
      cyc++;
      e_upd = 0;
      e_done = 0;
      if (start) begin
        m_start_cyc = cyc - 1;
        m_period = int'(period_in);
        ceil_v = (m_period == 0) ? 0 : m_period - 1;
        m_tgt = (int'(target_duty) < ceil_v) ? int'(target_duty) : ceil_v;
        m_ivl = int'(step_interval);
        if (m_duty > ceil_v) m_duty = ceil_v;
        e_upd = 1;
        if (m_duty == m_tgt) begin
          active = 0; done_at = cyc + 1;
        end else begin
          active = 1; done_at = -1; next_pulse = cyc + m_ivl + 1;
        end
      end else if (active && cyc == next_pulse) begin
        m_duty = m_duty + ((m_duty < m_tgt) ? 1 : -1);
        e_upd = 1;
        if (m_duty == m_tgt) begin
          active = 0; done_at = cyc + 1;
        end else begin
          next_pulse = next_pulse + m_ivl + 1;
        end
      end else if (cyc == done_at) begin
        e_done = 1;
        done_at = -1;
      end
      e_busy = active || e_upd;
    end
  end

  // Observation log of what the DUT actually emitted, relative to the start edge.
  int up_off[$];
  int up_duty[$];
  int up_per[$];
  int done_off = -1;
  int done_busy = 0;
  int done_seen = 0;

  always @(negedge clk) begin
    chk("period", int'(pwm_period), m_period);
    chk("duty", int'(pwm_duty_cycle), m_duty);
    chk("update", int'(update_parameters), int'(e_upd));
    chk("busy", int'(busy), int'(e_busy));
    chk("done", int'(done), int'(e_done));
    if (update_parameters) begin
      up_off.push_back(cyc - m_start_cyc);
      up_duty.push_back(int'(pwm_duty_cycle));
      up_per.push_back(int'(pwm_period));
      if (pwm_duty_cycle >= pwm_period && pwm_period != 4'd0)
        chk("duty_below_period", int'(pwm_duty_cycle), int'(pwm_period) - 1);
    end
    if (done) begin
      done_off = cyc - m_start_cyc;
      done_busy = int'(busy);
      done_seen++;
    end
  end

  task automatic do_start(input int p, input int t, input int iv);
    @(negedge clk);
    period_in = 4'(p);
    target_duty = 4'(t);
    step_interval = 8'(iv);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    up_off.delete();
    up_duty.delete();
    up_per.delete();
    done_off = -1;
  endtask

  task automatic wait_done(input string nm);
    bit got;
    got = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
    end
    chk({nm, " done_seen"}, int'(got), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string nm, input int n, input int ivl, input int d0,
                           input int dir, input int per, input int doff);
    chk({nm, " n_updates"}, up_duty.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < up_duty.size()) begin
        chk({nm, " upd_offset"}, up_off[i], 1 + i * (ivl + 1));
        chk({nm, " upd_duty"}, up_duty[i], d0 + dir * i);
        chk({nm, " upd_period"}, up_per[i], per);
      end
    end
    chk({nm, " done_offset"}, done_off, doff);
    if (doff >= 0) chk({nm, " busy_at_done"}, done_busy, 0);
  endtask

  int snap;

  initial begin
    reset = 1'b0;
    start = 1'b0;
    period_in = '0;
    target_duty = '0;
    step_interval = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_period", int'(pwm_period), 0);
    chk("rst_duty", int'(pwm_duty_cycle), 0);
    chk("rst_busy", int'(busy), 0);

    do_start(8, 5, 2);
    wait_done("ramp_up");
    check_log("ramp_up", 6, 2, 0, 1, 8, 17);

    do_start(8, 2, 0);
    wait_done("ramp_down");
    check_log("ramp_down", 4, 0, 5, -1, 8, 5);

    do_start(4, 9, 0);
    wait_done("clamp");
    check_log("clamp", 2, 0, 2, 1, 4, 3);

    do_start(0, 7, 5);
    wait_done("zero_period");
    check_log("zero_period", 1, 5, 0, 1, 0, 2);

    do_start(8, 5, 0);
    wait_done("to_five");
    check_log("to_five", 6, 0, 0, 1, 8, 7);
    do_start(4, 0, 1);
    wait_done("shrink");
    check_log("shrink", 4, 1, 3, -1, 4, 8);

    snap = done_seen;
    do_start(8, 7, 1);
    for (int i = 0; i < 50; i++) begin
      if (up_duty.size() >= 4) break;
      @(posedge clk);
      #1;
    end
    check_log("retarget_first", 4, 1, 0, 1, 8, -1);
    do_start(8, 1, 0);
    wait_done("retarget");
    check_log("retarget", 3, 0, 3, -1, 8, 4);
    chk("retarget done_count", done_seen - snap, 1);

    do_start(8, 6, 3);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_period", int'(pwm_period), 0);
    chk("async_duty", int'(pwm_duty_cycle), 0);
    chk("async_update", int'(update_parameters), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    do_start(8, 2, 0);
    wait_done("after_reset");
    check_log("after_reset", 3, 0, 0, 1, 8, 4);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
